fifo_producer: RTL and testbench
================================

Name: fifo_producer

Overview:
- Write-side traffic source for the asynchronous FIFO, running in the write clock domain (clk1).
- Generates a programmable number of bursts of data words, with a programmable idle gap between bursts.
- Drives Data_in and Write into the FIFO write control, and honours Full.
- Counterpart to the read-side consumer in clk2; used as the stimulus engine for FIFO throughput and ordering checks.

Parameters:
- WIDTH, 1024, data word width.
- PTR_WIDTH, 9, FIFO pointer width; sets the width of the burst-length field.
- CNT_WIDTH, 16, width of the burst-count, gap and word-sent counters.

Ports:
- clk1  input  1  write-domain clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse; starts a transfer, sampled in IDLE only.
- mode  input  1  0 = incrementing pattern, 1 = 32-bit LFSR pattern.
- seed  input  32  initial pattern value, latched on start.
- burst_len  input  PTR_WIDTH+1  words per burst, latched on start; 0 is treated as 1.
- gap_len  input  CNT_WIDTH  idle cycles between bursts, latched on start.
- num_bursts  input  CNT_WIDTH  bursts per transfer, latched on start; 0 finishes immediately.
- Full  input  1  FIFO full flag from the write control unit (already synchronized to clk1).
- Data_in  output  WIDTH  data word presented to the FIFO.
- Write  output  1  write enable to the FIFO.
- busy  output  1  high from the cycle after start until DONE.
- done  output  1  one-cycle pulse when the transfer completes.
- words_sent  output  CNT_WIDTH  accepted words since last start; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset is synchronous: while rst_n=0 at a posedge clk1:
  - state goes to IDLE;
  - Data_in, Write, busy, done, words_sent and all internal counters become 0.
  - Reset mid-burst abandons the transfer; no partial-word state is retained.
- Word acceptance: a word is accepted at a posedge where Write=1.
  - Write = (state==BURST) && !Full, decoded from registered state and the Full input; no Write is ever asserted while Full=1.
  - Data_in is registered and holds the current word stable across Full stalls; it advances only on acceptance.
- Pattern:
  - mode 0: value increments by 1 per accepted word, 32-bit, wraps 0xFFFFFFFF -> 0.
  - mode 1: Galois LFSR, taps 32,22,2,1 (mask 0x80200003), shifted once per accepted word; seed 0 is replaced by 1.
  - Data_in = 32-bit value zero-extended to WIDTH (truncated if WIDTH<32).
  - First word of the transfer equals seed (or 1 per the LFSR rule above).
- States:
  - IDLE: Write=0, busy=0. On start: latch config, load pattern, clear words_sent.
    - num_bursts=0 -> DONE.
    - Otherwise -> BURST.
  - BURST: on each acceptance, decrement the in-burst word counter.
    - Last word of the last burst accepted -> DONE.
    - Last word of any other burst, gap_len>0 -> GAP.
    - Last word of any other burst, gap_len=0 -> BURST again with no bubble, so Write can stay high across the burst boundary.
  - GAP: Write=0 for exactly gap_len cycles, then -> BURST.
  - DONE: done=1 for one cycle, busy=0, -> IDLE.
- start while not IDLE is ignored.
- Full held for many cycles: stay in BURST with Data_in frozen; there is no timeout.
- Full deasserting: Write rises in the same cycle, combinationally.
- words_sent increments by 1 per accepted word and saturates never (wraps).

Test Plan:
- Reset mid-burst: rst_n=0 for 1 cycle during BURST -> next cycle Write=0, busy=0, Data_in=0, words_sent=0; a later start restarts from seed.
- Gap-free incrementing: mode=0, seed=0x10, burst_len=4, gap_len=0, num_bursts=2, Full=0 -> Write high 8 consecutive cycles, Data_in 0x10..0x17, done pulses one cycle after the last word, words_sent=8.
- Gap timing: same stimulus with gap_len=3 -> Write high 4 cycles, low exactly 3 cycles, high 4 cycles; words_sent=8.
- Backpressure: Full=1 for 5 cycles after the 2nd word -> Write=0 and Data_in held at 0x11 throughout; sequence resumes 0x11, 0x12 with no loss or duplication.
- LFSR mode: mode=1, seed=0 -> first word 0x00000001, second 0x80200003 (0x1 shifted right, LSB=1 so XOR with mask), sequence matches the reference LFSR for 16 words.
- Edge configs:
  - num_bursts=0 -> done 1 cycle after start, Write never asserted.
  - burst_len=0 -> behaves as burst_len=1.
  - start asserted during BURST -> ignored, config unchanged.

Source files
------------

// File: rtl/fifo_producer.sv
// Write-side burst traffic source for the async FIFO (clk1 domain).
// Write is decoded from registered state and Full; Data_in only advances on acceptance.
module fifo_producer #(
   parameter int WIDTH     = 1024,
   parameter int PTR_WIDTH = 9,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk1,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 mode,
   input  logic [31:0]          seed,
   input  logic [PTR_WIDTH:0]   burst_len,
   input  logic [CNT_WIDTH-1:0] gap_len,
   input  logic [CNT_WIDTH-1:0] num_bursts,
   input  logic                 Full,
   output logic [WIDTH-1:0]     Data_in,
   output logic                 Write,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] words_sent
);

   typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP, S_DONE} state_t;

   localparam logic [31:0]          LFSR_MASK = 32'h8020_0003;
   localparam logic [PTR_WIDTH:0]   BLEN_ONE  = (PTR_WIDTH+1)'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = '0;

   state_t               state_q, state_d;
   logic                 mode_q, mode_d;
   logic [31:0]          pat_q, pat_d;
   logic [PTR_WIDTH:0]   blen_q, blen_d;
   logic [PTR_WIDTH:0]   word_cnt_q, word_cnt_d;
   logic [CNT_WIDTH-1:0] gap_q, gap_d;
   logic [CNT_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
   logic [CNT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
   logic [CNT_WIDTH-1:0] sent_q, sent_d;

   logic                 accept;
   logic [PTR_WIDTH:0]   blen_eff;
   logic [31:0]          pat_next;

   assign accept   = (state_q == S_BURST) && !Full;
   assign blen_eff = (burst_len == '0) ? BLEN_ONE : burst_len;
   assign pat_next = mode_q ? ((pat_q >> 1) ^ (pat_q[0] ? LFSR_MASK : 32'h0))
                            : (pat_q + 32'd1);

   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         mode_q      <= 1'b0;
         pat_q       <= '0;
         blen_q      <= '0;
         word_cnt_q  <= '0;
         gap_q       <= '0;
         gap_cnt_q   <= '0;
         burst_cnt_q <= '0;
         sent_q      <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         pat_q       <= pat_d;
         blen_q      <= blen_d;
         word_cnt_q  <= word_cnt_d;
         gap_q       <= gap_d;
         gap_cnt_q   <= gap_cnt_d;
         burst_cnt_q <= burst_cnt_d;
         sent_q      <= sent_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      pat_d       = pat_q;
      blen_d      = blen_q;
      word_cnt_d  = word_cnt_q;
      gap_d       = gap_q;
      gap_cnt_d   = gap_cnt_q;
      burst_cnt_d = burst_cnt_q;
      sent_d      = sent_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d      = mode;
               blen_d      = blen_eff;
               word_cnt_d  = blen_eff;
               gap_d       = gap_len;
               burst_cnt_d = num_bursts;
               pat_d       = (mode && (seed == 32'h0)) ? 32'h1 : seed;
               sent_d      = CNT_ZERO;
               state_d     = (num_bursts == CNT_ZERO) ? S_DONE : S_BURST;
            end
         end
         S_BURST: begin
            if (accept) begin
               pat_d  = pat_next;
               sent_d = sent_q + CNT_ONE;
               if (word_cnt_q == BLEN_ONE) begin
                  // Burst boundary: reload the word counter; gap_len=0 keeps Write continuous.
                  if (burst_cnt_q == CNT_ONE) begin
                     state_d = S_DONE;
                  end else begin
                     burst_cnt_d = burst_cnt_q - CNT_ONE;
                     word_cnt_d  = blen_q;
                     if (gap_q != CNT_ZERO) begin
                        gap_cnt_d = gap_q;
                        state_d   = S_GAP;
                     end
                  end
               end else begin
                  word_cnt_d = word_cnt_q - BLEN_ONE;
               end
            end
         end
         S_GAP: begin
            gap_cnt_d = gap_cnt_q - CNT_ONE;
            if (gap_cnt_q == CNT_ONE) begin
               state_d = S_BURST;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      Write = (state_q == S_BURST) && !Full;
      busy  = (state_q == S_BURST) || (state_q == S_GAP);
      done  = (state_q == S_DONE);
   end

   assign words_sent = sent_q;

   generate
      if (WIDTH > 32) begin : g_zext
         assign Data_in = {{(WIDTH-32){1'b0}}, pat_q};
      end else if (WIDTH == 32) begin : g_exact
         assign Data_in = pat_q;
      end else begin : g_trunc
         assign Data_in = pat_q[WIDTH-1:0];
      end
   endgenerate

endmodule

// File: tb/tb_fifo_producer.sv
// Directed and randomized bench for fifo_producer with a queue-based reference model.
module tb_fifo_producer;
   localparam int WIDTH     = 1024;
   localparam int PTR_WIDTH = 9;
   localparam int CNT_WIDTH = 16;

   logic                 clk1 = 1'b0;
   logic                 rst_n, start, mode, Full;
   logic [31:0]          seed;
   logic [PTR_WIDTH:0]   burst_len;
   logic [CNT_WIDTH-1:0] gap_len, num_bursts;
   logic [WIDTH-1:0]     Data_in;
   logic                 Write, busy, done;
   logic [CNT_WIDTH-1:0] words_sent;

   fifo_producer #(.WIDTH(WIDTH), .PTR_WIDTH(PTR_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk1(clk1), .rst_n(rst_n), .start(start), .mode(mode), .seed(seed),
      .burst_len(burst_len), .gap_len(gap_len), .num_bursts(num_bursts), .Full(Full),
      .Data_in(Data_in), .Write(Write), .busy(busy), .done(done), .words_sent(words_sent)
   );

   always #5 clk1 = ~clk1;

   int checks = 0;
   int failures = 0;

   // Observation log: every negedge sees the values the next posedge will capture.
   logic [31:0] wq[$];
   bit          trace[$];
   int          hold_viol = 0, full_viol = 0, upper_viol = 0;
   logic        prev_w = 1'b0, prev_busy = 1'b0;
   logic [31:0] prev_data = '0;

   always @(negedge clk1) begin
      trace.push_back(Write === 1'b1);
      if (Write === 1'b1) wq.push_back(Data_in[31:0]);
      if (Write === 1'b1 && Full === 1'b1) full_viol++;
      if (Data_in[WIDTH-1:32] !== '0 && rst_n === 1'b1) upper_viol++;
      if (prev_busy && busy === 1'b1 && !prev_w && Data_in[31:0] !== prev_data) hold_viol++;
      prev_w    = (Write === 1'b1);
      prev_busy = (busy === 1'b1);
      prev_data = Data_in[31:0];
   end

   logic [31:0] exp_q[$];
   int          last_wbase;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Reference word stream straight from the pattern rules.
   task automatic build_exp(input bit m, input logic [31:0] s, input int n);
      logic [31:0] v;
      exp_q.delete();
      v = (m && s == 32'h0) ? 32'h1 : s;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(v);
         if (m) v = (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
         else   v = v + 32'd1;
      end
   endtask

   task automatic start_xfer(input bit m, input logic [31:0] s, input int bl, input int gp, input int nb);
      @(posedge clk1); #1;
      mode = m; seed = s; burst_len = bl[PTR_WIDTH:0];
      gap_len = gp[CNT_WIDTH-1:0]; num_bursts = nb[CNT_WIDTH-1:0]; start = 1'b1;
      @(posedge clk1); #1;
      start = 1'b0;
      // Scramble config inputs to show they were latched.
      mode = $urandom; seed = $urandom; burst_len = $urandom; gap_len = $urandom; num_bursts = $urandom;
   endtask

   task automatic wait_done(input bit rnd, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (rnd) Full = ($urandom_range(0, 2) == 0);
         @(negedge clk1); #1;
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk1); #1;
      end
      Full = 1'b0;
   endtask

   task automatic check_words(input string tag, input int wbase, input int n);
      int mism;
      mism = 0;
      chk({tag, "_count"}, wq.size() - wbase, n);
      for (int i = 0; i < n; i++)
         if (wbase + i >= wq.size() || wq[wbase + i] !== exp_q[i]) mism++;
      chk({tag, "_data"}, mism, 0);
      chk({tag, "_words_sent"}, words_sent, n % 65536);
   endtask

   task automatic run_xfer(input string tag, input bit m, input logic [31:0] s, input int bl,
                           input int gp, input int nb, input bit rnd, input bit chk_trace);
      int  eb, n, wbase, tbase, mism;
      bit  ok;
      bit  et[$];
      eb = (bl == 0) ? 1 : bl;
      n  = eb * nb;
      build_exp(m, s, n);
      start_xfer(m, s, bl, gp, nb);
      wbase = wq.size();
      tbase = trace.size();
      last_wbase = wbase;
      wait_done(rnd, n * 4 + gp * nb + 40, ok);
      chk({tag, "_done_seen"}, ok, 1);
      check_words(tag, wbase, n);
      chk({tag, "_busy_in_done"}, busy, 0);
      if (chk_trace) begin
         for (int b = 0; b < nb; b++) begin
            for (int w = 0; w < eb; w++) et.push_back(1'b1);
            if (b < nb - 1) for (int g = 0; g < gp; g++) et.push_back(1'b0);
         end
         et.push_back(1'b0);
         chk({tag, "_trace_len"}, trace.size() - tbase, et.size());
         mism = 0;
         for (int i = 0; i < et.size(); i++)
            if (tbase + i >= trace.size() || trace[tbase + i] != et[i]) mism++;
         chk({tag, "_trace"}, mism, 0);
      end
      @(posedge clk1); #1;
      @(negedge clk1); #1;
      chk({tag, "_done_pulse"}, done, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int  wbase, stall_bad;
      bit  ok;
      int  bl, gp, nb;
      bit  m;
      logic [31:0] s;

      rst_n = 1'b0; start = 1'b0; mode = 1'b0; seed = '0; burst_len = '0;
      gap_len = '0; num_bursts = '0; Full = 1'b0;
      repeat (3) @(posedge clk1);
      @(negedge clk1); #1;
      chk("reset_write", Write, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_words_sent", words_sent, 0);
      chk("reset_data_zero", Data_in == '0, 1);
      @(posedge clk1); #1;
      rst_n = 1'b1;

      run_xfer("incr_nogap", 1'b0, 32'h10, 4, 0, 2, 1'b0, 1'b1);
      chk("incr_nogap_last", wq[wq.size() - 1], 32'h17);
      run_xfer("incr_gap3", 1'b0, 32'h10, 4, 3, 2, 1'b0, 1'b1);

      // Backpressure while the second word is presented.
      build_exp(1'b0, 32'h10, 8);
      start_xfer(1'b0, 32'h10, 4, 0, 2);
      wbase = wq.size();
      @(posedge clk1); #1;
      Full = 1'b1;
      stall_bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk1); #1;
         if (Write !== 1'b0 || Data_in[31:0] !== 32'h11) stall_bad++;
         @(posedge clk1); #1;
      end
      chk("bp_stall", stall_bad, 0);
      Full = 1'b0;
      #1;
      chk("bp_write_resume", Write, 1);
      chk("bp_data_resume", Data_in[31:0], 32'h11);
      wait_done(1'b0, 60, ok);
      chk("bp_done_seen", ok, 1);
      check_words("bp", wbase, 8);

      run_xfer("lfsr", 1'b1, 32'h0, 16, 0, 1, 1'b0, 1'b1);
      chk("lfsr_w0", wq[last_wbase], 32'h0000_0001);
      chk("lfsr_w1", wq[last_wbase + 1], 32'h8020_0003);

      run_xfer("nb0", 1'b0, 32'h55, 3, 2, 0, 1'b0, 1'b1);
      run_xfer("blen0", 1'b0, 32'h200, 0, 2, 3, 1'b0, 1'b1);

      // A start pulse mid-transfer must not disturb the running config.
      build_exp(1'b0, 32'h100, 12);
      start_xfer(1'b0, 32'h100, 6, 1, 2);
      wbase = wq.size();
      @(posedge clk1); #1;
      mode = 1'b1; seed = 32'h5; burst_len = 1; gap_len = 0; num_bursts = 0; start = 1'b1;
      @(posedge clk1); #1;
      start = 1'b0;
      wait_done(1'b0, 100, ok);
      chk("ign_done_seen", ok, 1);
      check_words("ign", wbase, 12);

      // Reset in the middle of a burst.
      start_xfer(1'b1, 32'hABCD, 10, 0, 3);
      @(posedge clk1); #1;
      @(posedge clk1); #1;
      rst_n = 1'b0;
      @(posedge clk1); #1;
      rst_n = 1'b1;
      @(negedge clk1); #1;
      chk("rst_mid_write", Write, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_data", Data_in == '0, 1);
      chk("rst_mid_words_sent", words_sent, 0);
      run_xfer("after_reset", 1'b1, 32'hABCD, 3, 1, 2, 1'b0, 1'b1);
      chk("after_reset_first", wq[last_wbase], 32'hABCD);

      for (int k = 0; k < 6; k++) begin
         m  = $urandom_range(0, 1);
         s  = $urandom;
         bl = $urandom_range(0, 12);
         gp = $urandom_range(0, 4);
         nb = $urandom_range(0, 4);
         run_xfer("rand", m, s, bl, gp, nb, 1'b1, 1'b0);
      end

      chk("write_while_full", full_viol, 0);
      chk("data_hold_stall", hold_viol, 0);
      chk("upper_bits_zero", upper_viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
